branch_resolve_unit: RTL and testbench



---
 rtl/bru_pkg.sv | 25 ++
 rtl/bru_cond_eval.sv | 32 +++
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and flag bit positions for the branch resolve unit
package bru_pkg;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_GT = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_LE = 3'd5,
    COND_CS = 3'd6,
    COND_AL = 3'd7
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_cond_eval.sv
// rtl/bru_cond_eval.sv - combinational condition-code evaluation against {N,Z,C,V}
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       met
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    met = 1'b0;
    case (cond_e'(cond))
      COND_EQ: met = z;
      COND_NE: met = !z;
      COND_GT: met = !z && (n == v);
      COND_LT: met = (n != v);
      COND_GE: met = (n == v);
      COND_LE: met = z || (n != v);
      COND_CS: met = c;
      COND_AL: met = 1'b1;
      default: met = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolution, redirect and flush; BRU_PERF_EN adds perf counters
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flags_we,
  input  logic [3:0]      flags_in,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic            br_uncond,
  input  logic            br_pred_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] br_fallthru,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
`ifdef BRU_PERF_EN
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts,
`endif
  output logic [3:0]      flags_q
);

  bru_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      flags_d;
  logic            res_valid_q, res_taken_q, res_mispredict_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic [3:0]      eff_flags;
  logic            cond_met, taken, accept;

  // A branch issued alongside an ALU flag write sees the new flags.
  assign eff_flags = flags_we ? flags_in : flags_q;
  assign flags_d   = flags_we ? flags_in : flags_q;

  bru_cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (br_cond),
    .met   (cond_met)
  );

  assign taken  = br_uncond | cond_met;
  assign accept = br_valid & br_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (taken ^ br_pred_taken)) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_ready = 1'b1;
    flush    = 1'b0;
    if (state_q == FLUSH) begin
      br_ready = 1'b0;
      flush    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q          <= 4'd0;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      flags_q     <= flags_d;
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q      <= taken;
        res_mispredict_q <= taken ^ br_pred_taken;
        redirect_pc_q    <= taken ? br_target : br_fallthru;
      end
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef BRU_PERF_EN
  logic [CNT_W-1:0] perf_branches_q, perf_mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else if (res_valid_q) begin
      perf_branches_q <= perf_branches_q + 1'b1;
      if (res_mispredict_q) begin
        perf_mispredicts_q <= perf_mispredicts_q + 1'b1;
      end
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed-vector bench for branch_resolve_unit (perf checks with BRU_PERF_EN)
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic        br_uncond;
  logic        br_pred_taken;
  logic [31:0] br_target;
  logic [31:0] br_fallthru;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [3:0]  flags_q;
  logic [3:0]  perf_branches;
  logic [3:0]  perf_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flags_we       (flags_we),
    .flags_in       (flags_in),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_uncond      (br_uncond),
    .br_pred_taken  (br_pred_taken),
    .br_target      (br_target),
    .br_fallthru    (br_fallthru),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
`ifdef BRU_PERF_EN
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
`endif
    .flags_q        (flags_q)
  );

`ifndef BRU_PERF_EN
  assign perf_branches    = 4'd0;
  assign perf_mispredicts = 4'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Independent reading of the condition-code table, flags = {N,Z,C,V}.
  function automatic logic cond_model(input logic [2:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !z && (n == v);
      3'd3: return n != v;
      3'd4: return n == v;
      3'd5: return z || (n != v);
      3'd6: return cy;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_we = 1'b1;
    flags_in = f;
    tick();
    flags_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic u, input logic p,
                       input logic [31:0] t, input logic [31:0] ft,
                       input logic fwe, input logic [3:0] fin);
    br_valid      = 1'b1;
    br_cond       = c;
    br_uncond     = u;
    br_pred_taken = p;
    br_target     = t;
    br_fallthru   = ft;
    flags_we      = fwe;
    flags_in      = fin;
    tick();
    br_valid = 1'b0;
    flags_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!br_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", br_ready, 1'b1);
  endtask

  initial begin
    logic exp_t;
    rst_n = 1'b0; flags_we = 1'b0; flags_in = 4'd0; br_valid = 1'b0;
    br_cond = 3'd0; br_uncond = 1'b0; br_pred_taken = 1'b0;
    br_target = 32'd0; br_fallthru = 32'd0;
    #12;
    check("rst_flags", flags_q, 4'd0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_taken", res_taken, 1'b0);
    check("rst_mispredict", res_mispredict, 1'b0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_flush", flush, 1'b0);
    check("rst_ready", br_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // EQ with Z set, predicted taken
    set_flags(4'b0100);
    check("flags_write", flags_q, 4'b0100);
    issue(3'd0, 1'b0, 1'b1, 32'h200, 32'h204, 1'b0, 4'd0);
    check("eq_valid", res_valid, 1'b1);
    check("eq_taken", res_taken, 1'b1);
    check("eq_mispredict", res_mispredict, 1'b0);
    check("eq_redirect", redirect_pc, 32'h200);
    check("eq_flush", flush, 1'b0);
    check("eq_ready", br_ready, 1'b1);
    tick();
    check("eq_pulse_end", res_valid, 1'b0);
    check("eq_redirect_hold", redirect_pc, 32'h200);

    // GT mispredict with a stalled request and a flag write during flush
    set_flags(4'b1100);
    issue(3'd2, 1'b0, 1'b1, 32'h100, 32'h0F4, 1'b0, 4'd0);
    check("gt_valid", res_valid, 1'b1);
    check("gt_taken", res_taken, 1'b0);
    check("gt_mispredict", res_mispredict, 1'b1);
    check("gt_redirect", redirect_pc, 32'h0F4);
    check("gt_flush_c1", flush, 1'b1);
    check("gt_ready_c1", br_ready, 1'b0);
    br_valid = 1'b1; br_cond = 3'd7; br_pred_taken = 1'b0;
    flags_we = 1'b1; flags_in = 4'b0011;
    tick();
    flags_we = 1'b0;
    check("gt_flush_c2", flush, 1'b1);
    check("gt_ready_c2", br_ready, 1'b0);
    check("gt_blocked", res_valid, 1'b0);
    check("flags_in_flush", flags_q, 4'b0011);
    tick();
    br_valid = 1'b0;
    check("gt_flush_end", flush, 1'b0);
    check("gt_ready_end", br_ready, 1'b1);
    check("gt_still_blocked", res_valid, 1'b0);

    // Forwarding
    set_flags(4'b0000);
    issue(3'd4, 1'b0, 1'b0, 32'h300, 32'h304, 1'b1, 4'b1001);
    check("fwd_ge_taken", res_taken, 1'b1);
    check("fwd_ge_mispredict", res_mispredict, 1'b1);
    check("fwd_ge_redirect", redirect_pc, 32'h300);
    check("fwd_ge_flags", flags_q, 4'b1001);
    wait_ready();
    set_flags(4'b0000);
    issue(3'd0, 1'b0, 1'b0, 32'h400, 32'h404, 1'b1, 4'b0100);
    check("fwd_eq_taken", res_taken, 1'b1);
    check("fwd_eq_redirect", redirect_pc, 32'h400);
    wait_ready();

    // Condition sweep through the flag register
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_flags(4'(f));
        exp_t = cond_model(3'(c), 4'(f));
        issue(3'(c), 1'b0, f[0], 32'h1000 + 32'(c * 16 + f), 32'h8000 + 32'(f), 1'b0, 4'd0);
        check($sformatf("sw_taken_c%0d_f%0d", c, f), res_taken, exp_t);
        check($sformatf("sw_mis_c%0d_f%0d", c, f), res_mispredict, exp_t ^ f[0]);
        check($sformatf("sw_pc_c%0d_f%0d", c, f), redirect_pc,
              exp_t ? 32'h1000 + 32'(c * 16 + f) : 32'h8000 + 32'(f));
        wait_ready();
      end
    end

    // Unconditional overrides a failing NE
    set_flags(4'b0100);
    issue(3'd1, 1'b1, 1'b1, 32'h500, 32'h504, 1'b0, 4'd0);
    check("uncond_taken", res_taken, 1'b1);
    check("uncond_mispredict", res_mispredict, 1'b0);
    check("uncond_redirect", redirect_pc, 32'h500);

    // Back-to-back correct predictions
    set_flags(4'b0000);
    issue(3'd7, 1'b0, 1'b1, 32'h600, 32'h604, 1'b0, 4'd0);
    check("b2b_ready", br_ready, 1'b1);
    issue(3'd0, 1'b0, 1'b0, 32'h700, 32'h704, 1'b0, 4'd0);
    check("b2b_valid", res_valid, 1'b1);
    check("b2b_redirect", redirect_pc, 32'h704);

    // Reset during flush
    set_flags(4'b1111);
    issue(3'd7, 1'b0, 1'b0, 32'h900, 32'h904, 1'b0, 4'd0);
    check("rf_flush_before", flush, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_flush", flush, 1'b0);
    check("rf_ready", br_ready, 1'b1);
    check("rf_flags", flags_q, 4'd0);
    check("rf_res_valid", res_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rf_flush_after", flush, 1'b0);

`ifdef BRU_PERF_EN
    // 5 branches, 2 mispredicted, then 12 more to wrap a 4-bit counter
    check("perf_rst_br", perf_branches, 4'd0);
    set_flags(4'b0100);
    issue(3'd0, 1'b0, 1'b1, 32'h10, 32'h14, 1'b0, 4'd0);
    issue(3'd1, 1'b0, 1'b1, 32'h20, 32'h24, 1'b0, 4'd0);
    wait_ready();
    issue(3'd7, 1'b0, 1'b1, 32'h30, 32'h34, 1'b0, 4'd0);
    issue(3'd6, 1'b0, 1'b0, 32'h40, 32'h44, 1'b0, 4'd0);
    issue(3'd5, 1'b0, 1'b0, 32'h50, 32'h54, 1'b0, 4'd0);
    wait_ready();
    tick();
    check("perf_branches_5", perf_branches, 4'd5);
    check("perf_mispredicts_2", perf_mispredicts, 4'd2);
    for (int i = 0; i < 12; i++) begin
      issue(3'd7, 1'b0, 1'b1, 32'h60, 32'h64, 1'b0, 4'd0);
    end
    tick();
    check("perf_branches_wrap", perf_branches, 4'd1);
    check("perf_mispredicts_hold", perf_mispredicts, 4'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
